uart_cmd_decoder: RTL

- Receive-side command path for the game over the serial link.
- Takes bytes from the UART receiver (o_rx_data/o_rx_valid) and decodes keystrokes into the 3-bit direction code used by the joystick path: 0 up, 1 right, 2 down, 3 left, 4 none.
- Decodes WASD letters and ANSI arrow-key escape sequences (ESC '[' A/B/C/D), plus a game-reset request.
- Output is a held level, so it can feed the direction debouncer in place of, or muxed with, the joystick direction.

---
 rtl/uart_cmd_decoder.sv | 110 +++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns received UART keystrokes (WASD, ANSI arrows, 'r') into a held joystick direction
module uart_cmd_decoder #(
    parameter int HOLD_CYCLES = 1000000,
    parameter int ESC_TIMEOUT = 50000,
    parameter int CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [2:0] dir,
    output logic       rst_req,
    output logic       cmd_drop,
    output logic       bad_byte
);
    typedef enum logic [1:0] {IDLE, ESC, CSI} state_t;
    localparam logic [2:0] NONE = 3'd4;
    state_t state, state_nx;
    logic [1:0] rst_sync;
    logic run_n;
    logic [CNT_W-1:0] tcnt, hcnt;
    logic [2:0] id_code, code;
    logic id_rst, id_esc, id_bad, req, bad, t_clr, issue, hold;
    assign run_n = rst_sync[1];
    assign issue = code != NONE;
    assign hold  = dir != NONE;
    // Assert internal reset immediately, release it two edges after rst rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else rst_sync <= {rst_sync[0], 1'b1};
    end
    // Decode a byte as it would be seen in IDLE (also reused for the byte that ends a bare ESC)
    always_comb begin
        id_code = NONE;
        id_rst  = 1'b0;
        id_esc  = 1'b0;
        id_bad  = 1'b0;
        case (rx_data)
            8'h77, 8'h57: id_code = 3'd0;
            8'h64, 8'h44: id_code = 3'd1;
            8'h73, 8'h53: id_code = 3'd2;
            8'h61, 8'h41: id_code = 3'd3;
            8'h72, 8'h52: id_rst = 1'b1;
            8'h1B:        id_esc = 1'b1;
            8'h0D, 8'h0A, 8'h20: ;
            default:      id_bad = 1'b1;
        endcase
    end
    // Parser next state, issued direction and pulse requests
    always_comb begin
        state_nx = state;
        code     = NONE;
        req      = 1'b0;
        bad      = 1'b0;
        t_clr    = 1'b0;
        if (rx_valid) begin
            t_clr = 1'b1;
            if (state == CSI) begin
                code = rx_data == 8'h41 ? 3'd0 :
                       rx_data == 8'h43 ? 3'd1 :
                       rx_data == 8'h42 ? 3'd2 :
                       rx_data == 8'h44 ? 3'd3 : NONE;
                bad = code == NONE && rx_data != 8'h1B;
                state_nx = rx_data == 8'h1B ? ESC : IDLE;
            end else if (state == ESC && rx_data == 8'h5B) begin
                state_nx = CSI;
            end else begin
                code = id_code;
                req = id_rst;
                bad = id_bad;
                state_nx = id_esc ? ESC : IDLE;
            end
        end else if (state != IDLE && tcnt == CNT_W'(ESC_TIMEOUT - 1)) begin
            state_nx = IDLE;
            bad = state == CSI;
        end
    end
    // Parser state, escape timeout counter and one-cycle pulses
    always_ff @(posedge clk or negedge run_n) begin
        if (!run_n) begin
            state    <= IDLE;
            tcnt     <= '0;
            rst_req  <= 1'b0;
            cmd_drop <= 1'b0;
            bad_byte <= 1'b0;
        end else begin
            state    <= state_nx;
            tcnt     <= (t_clr || state == IDLE) ? '0 : tcnt + 1'b1;
            rst_req  <= req;
            cmd_drop <= issue && hold;
            bad_byte <= bad;
        end
    end
    // Hold the issued direction for HOLD_CYCLES cycles; a reset request cancels it
    always_ff @(posedge clk or negedge run_n) begin
        if (!run_n) begin
            dir  <= NONE;
            hcnt <= '0;
        end else if (req) begin
            dir  <= NONE;
            hcnt <= '0;
        end else if (issue && !hold) begin
            dir  <= code;
            hcnt <= '0;
        end else if (hold) begin
            dir  <= hcnt == CNT_W'(HOLD_CYCLES - 1) ? NONE : dir;
            hcnt <= hcnt + 1'b1;
        end
    end
endmodule
